// File: rtl/pc_update_unit_if.sv
// pc_update_unit_if: control inputs and PC/EPC/status outputs of the PC update stage
interface pc_update_unit_if;
    logic [31:0] pc_next;
    logic        PCWrite;
    logic        PCWriteCond;
    logic [1:0]  BranchOp;
    logic        zero;
    logic        gt;
    logic        EPCWrite;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        pc_written;
    logic        halted;
    logic        addr_err;
    logic [31:0] write_count;
    modport master (
        output pc_next, PCWrite, PCWriteCond, BranchOp, zero, gt, EPCWrite, halt_req, resume,
        input  pc, epc, pc_written, halted, addr_err, write_count
    );
    modport slave (
        input  pc_next, PCWrite, PCWriteCond, BranchOp, zero, gt, EPCWrite, halt_req, resume,
        output pc, epc, pc_written, halted, addr_err, write_count
    );
endinterface

// File: rtl/pc_update_unit.sv
// pc_update_unit: architectural PC with branch-conditional writes, EPC, halt state and write counter
module pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic reset,
    pc_update_unit_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nx;
    logic cond, req, aligned, do_write, bad;
    always_comb begin
        cond = bus.BranchOp[1] ? (bus.BranchOp[0] ? bus.gt : !bus.gt)
                               : (bus.BranchOp[0] ? !bus.zero : bus.zero);
        req = bus.PCWrite | (bus.PCWriteCond & cond);
        aligned = bus.pc_next[1:0] == 2'b00;
        do_write = (state == RUN) & req & aligned;
        bad = (state == RUN) & req & !aligned;
        state_nx = (state == RUN) ? ((bad | bus.halt_req) ? HALT : RUN)
                                  : (bus.resume ? RUN : HALT);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
            bus.pc <= RESET_PC;
            bus.epc <= 32'h0;
            bus.write_count <= 32'h0;
            bus.pc_written <= 1'b0;
            bus.addr_err <= 1'b0;
        end else begin
            state <= state_nx;
            bus.pc <= do_write ? bus.pc_next : bus.pc;
            bus.epc <= bus.EPCWrite ? bus.pc - 32'd4 : bus.epc;
            bus.write_count <= bus.write_count + {31'h0, do_write};
            bus.pc_written <= do_write;
            bus.addr_err <= bad;
        end
    end
    assign bus.halted = state == HALT;
endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit: directed stimulus with a scoreboard queue of expected outputs
module tb_pc_update_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] wc;
        logic        pw;
        logic        ae;
        logic        h;
    } exp_t;
    exp_t q[$];
    logic [31:0] m_pc, m_epc, m_wc;
    logic        m_halt;
    pc_update_unit_if bus ();
    pc_update_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask
    // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
    task automatic step(input logic rstn, input logic [31:0] nx, input logic pw, input logic pwc,
                        input logic [1:0] bop, input logic z, input logic g,
                        input logic ew, input logic hr, input logic rs, input string tag);
        exp_t e;
        logic c, r;
        reset = rstn;
        bus.pc_next = nx; bus.PCWrite = pw; bus.PCWriteCond = pwc; bus.BranchOp = bop;
        bus.zero = z; bus.gt = g; bus.EPCWrite = ew; bus.halt_req = hr; bus.resume = rs;
        e.pw = 1'b0;
        e.ae = 1'b0;
        if (!rstn) begin
            m_pc = 32'h0; m_epc = 32'h0; m_wc = 32'h0; m_halt = 1'b0;
        end else begin
            case (bop)
                2'b00: c = z;
                2'b01: c = !z;
                2'b10: c = !g;
                default: c = g;
            endcase
            r = pw || (pwc && c);
            if (ew) m_epc = m_pc - 32'd4;
            if (m_halt) begin
                m_halt = !rs;
            end else if (r && nx[1:0] != 2'b00) begin
                e.ae = 1'b1;
                m_halt = 1'b1;
            end else begin
                if (r) begin
                    m_pc = nx;
                    m_wc = m_wc + 32'd1;
                    e.pw = 1'b1;
                end
                m_halt = hr;
            end
        end
        e.pc = m_pc; e.epc = m_epc; e.wc = m_wc; e.h = m_halt;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".pc"}, bus.pc, e.pc);
        chk({tag, ".epc"}, bus.epc, e.epc);
        chk({tag, ".write_count"}, bus.write_count, e.wc);
        chk({tag, ".pc_written"}, {31'h0, bus.pc_written}, {31'h0, e.pw});
        chk({tag, ".addr_err"}, {31'h0, bus.addr_err}, {31'h0, e.ae});
        chk({tag, ".halted"}, {31'h0, bus.halted}, {31'h0, e.h});
    endtask
    initial begin
        // args: rstn, pc_next, PCWrite, PCWriteCond, BranchOp, zero, gt, EPCWrite, halt_req, resume
        step(0, 32'h0000_0010, 1, 0, 2'b00, 0, 0, 1, 1, 0, "reset_with_write");
        step(1, 32'h0000_0004, 1, 0, 2'b00, 0, 0, 0, 0, 0, "pcwrite_4");
        step(1, 32'h0000_0008, 0, 0, 2'b00, 0, 0, 0, 0, 0, "idle");
        step(1, 32'h0000_0040, 0, 1, 2'b00, 0, 1, 0, 0, 0, "beq_nt");
        step(1, 32'h0000_0040, 0, 1, 2'b00, 1, 0, 0, 0, 0, "beq_t");
        step(1, 32'h0000_0080, 0, 1, 2'b01, 1, 0, 0, 0, 0, "bne_nt");
        step(1, 32'h0000_0080, 0, 1, 2'b01, 0, 1, 0, 0, 0, "bne_t");
        step(1, 32'h0000_00C0, 0, 1, 2'b10, 0, 1, 0, 0, 0, "ble_nt");
        step(1, 32'h0000_00C0, 0, 1, 2'b10, 1, 0, 0, 0, 0, "ble_t");
        step(1, 32'h0000_0100, 0, 1, 2'b11, 1, 0, 0, 0, 0, "bgt_nt");
        step(1, 32'h0000_0100, 0, 1, 2'b11, 0, 1, 0, 0, 0, "bgt_t");
        step(1, 32'h0000_0042, 1, 0, 2'b00, 0, 0, 0, 0, 0, "misaligned");
        step(1, 32'h0000_0044, 0, 0, 2'b00, 0, 0, 0, 0, 0, "misaligned_after");
        step(1, 32'h0000_0044, 0, 0, 2'b00, 0, 0, 0, 0, 1, "resume");
        step(1, 32'h0000_0104, 1, 1, 2'b00, 0, 0, 0, 1, 0, "halt_with_write");
        step(1, 32'h0000_0108, 1, 0, 2'b00, 0, 0, 0, 0, 0, "halt_ignore_write");
        step(1, 32'h0000_010A, 1, 0, 2'b00, 0, 0, 0, 1, 0, "halt_ignore_misaligned");
        step(1, 32'h0000_0108, 0, 1, 2'b00, 1, 0, 0, 1, 1, "halt_and_resume");
        step(1, 32'h0000_0200, 1, 1, 2'b00, 0, 0, 0, 0, 0, "pcwrite_dominates");
        step(1, 32'h0000_0300, 0, 0, 2'b00, 0, 0, 1, 0, 0, "epc_200");
        step(1, 32'h0000_0000, 1, 0, 2'b00, 0, 0, 1, 0, 0, "epc_uses_old_pc");
        step(1, 32'h0000_0000, 0, 0, 2'b00, 0, 0, 1, 0, 0, "epc_wrap");
        for (int i = 0; i < 3; i++)
            step(1, 32'h0000_0010 + 32'(i) * 4, 1, 0, 2'b00, 0, 0, 0, 0, 0, "held_write");
        step(1, 32'h0000_0050, 0, 0, 2'b00, 0, 0, 1, 1, 0, "halt_again");
        step(1, 32'h0000_0060, 0, 0, 2'b00, 0, 0, 1, 0, 0, "epc_in_halt");
        step(0, 32'h0000_0070, 1, 0, 2'b00, 0, 0, 1, 0, 1, "reset_in_halt");
        step(1, 32'h0000_0070, 0, 0, 2'b00, 0, 0, 0, 0, 0, "after_reset");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
